// File: rtl/apb4_reg_bridge.sv
// -----------------------------------------------------------------------------
// apb4_reg_bridge
//
// APB4 completer that turns each APB4 transfer into a single request on a
// simple register bus (the Bus2Reg side). It registers the request, inserts
// APB wait states until the register map answers with bus_ready, and rejects
// addresses that fall outside the register-bus address range.
//
// Optional feature (compile-time macro APB4_REG_BRIDGE_TIMEOUT_EN):
//   When defined, a wait-state counter bounds the time spent waiting for
//   bus_ready. After TIMEOUT_CYCLES wait cycles without a response the transfer
//   is completed with PSLVERR=1 and PRDATA=0. Without the macro no counter is
//   built and the bridge waits indefinitely.
//
// Parameters:
//   DATA_WIDTH     APB and register-bus data width (multiple of 8)
//   ADDR_WIDTH     register-bus address width
//   APB_ADDR_WIDTH PADDR width (>= ADDR_WIDTH)
//   TIMEOUT_CYCLES wait-cycle limit, used only with the timeout feature
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   PSEL .. PPROT      APB4 completer inputs (PPROT is ignored)
//   PREADY, PRDATA,    APB4 completer outputs, all registered
//   PSLVERR
//   bus_req            one-cycle register request pulse
//   bus_req_is_wr      1 = write request
//   bus_addr           register address (low ADDR_WIDTH bits of PADDR)
//   bus_wr_data        write data
//   bus_wr_biten       byte enables (PSTRB for writes, 0 for reads)
//   bus_req_stall_wr   write outstanding, waiting for bus_ready
//   bus_req_stall_rd   read outstanding, waiting for bus_ready
//   bus_ready          register-map completion
//   bus_err            register-map error, sampled with bus_ready
//   bus_rd_data        register-map read data, sampled with bus_ready
//   fsm_state          current FSM state for observation (IDLE=0, REQ=1,
//                      WAIT=2, RESP=3, ERR=4)
//
// Handshake semantics: an APB transfer is accepted only from IDLE on a setup
// phase (PSEL=1, PENABLE=0). Exactly one bus_req pulse is issued per in-range
// transfer and no further request is issued until the register map answers
// with bus_ready (bus_err and bus_rd_data are only meaningful in that cycle).
// PREADY is raised for exactly one cycle, the cycle after bus_ready is
// sampled; bus_ready seen outside REQ/WAIT has no effect.
// -----------------------------------------------------------------------------
module apb4_reg_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  // APB4 completer
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB,
  input  logic [2:0]                PPROT,
  output logic                      PREADY,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PSLVERR,
  // register bus
  output logic                      bus_req,
  output logic                      bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [DATA_WIDTH-1:0]     bus_wr_data,
  output logic [DATA_WIDTH/8-1:0]   bus_wr_biten,
  output logic                      bus_req_stall_wr,
  output logic                      bus_req_stall_rd,
  input  logic                      bus_ready,
  input  logic                      bus_err,
  input  logic [DATA_WIDTH-1:0]     bus_rd_data,
  // observation
  output logic [2:0]                fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t state;

  // Set once PSEL has been seen low while the bus side is still busy; the
  // bus handshake is then finished silently, without a PREADY.
  logic psel_lost;

  logic setup_phase;
  logic addr_out_of_range;
  logic abandon;

  assign setup_phase       = PSEL & ~PENABLE;
  // Any set bit above the register-bus address range is an error. Shifting
  // instead of slicing keeps this legal when APB_ADDR_WIDTH == ADDR_WIDTH.
  assign addr_out_of_range = |(PADDR >> ADDR_WIDTH);
  assign abandon           = psel_lost | ~PSEL;

  assign fsm_state = state;

  // PPROT carries no meaning for this register map.
  logic unused_inputs;
  assign unused_inputs = (^PPROT) ^ (TIMEOUT_CYCLES == 0);

`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
  localparam int TMO_CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(TIMEOUT_CYCLES - 1);

  logic [TMO_CW-1:0] tmo_cnt;
  logic              timeout_hit;

  // The counter holds the number of completed wait cycles; the wait cycle
  // that would bring it to TIMEOUT_CYCLES ends the transfer.
  assign timeout_hit = (state == S_WAIT) && (tmo_cnt == TMO_LAST);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      psel_lost        <= 1'b0;
      PREADY           <= 1'b0;
      PRDATA           <= '0;
      PSLVERR          <= 1'b0;
      bus_req          <= 1'b0;
      bus_req_is_wr    <= 1'b0;
      bus_addr         <= '0;
      bus_wr_data      <= '0;
      bus_wr_biten     <= '0;
      bus_req_stall_wr <= 1'b0;
      bus_req_stall_rd <= 1'b0;
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
      tmo_cnt          <= '0;
`endif
    end else begin
      // Pulse-style outputs default low; only the transitions below raise them.
      bus_req <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;

      case (state)
        S_IDLE: begin
          psel_lost <= 1'b0;
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
          if (setup_phase) begin
            bus_addr      <= PADDR[ADDR_WIDTH-1:0];
            bus_req_is_wr <= PWRITE;
            bus_wr_data   <= PWDATA;
            bus_wr_biten  <= PWRITE ? PSTRB : '0;
            if (addr_out_of_range) begin
              // Rejected without touching the register map.
              state   <= S_ERR;
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
              PRDATA  <= '0;
            end else begin
              state   <= S_REQ;
              bus_req <= 1'b1;
            end
          end
        end

        S_REQ, S_WAIT: begin
          psel_lost <= psel_lost | ~PSEL;
          if (bus_ready) begin
            bus_req_stall_wr <= 1'b0;
            bus_req_stall_rd <= 1'b0;
            if (abandon) begin
              state <= S_IDLE;
            end else begin
              state   <= S_RESP;
              PREADY  <= 1'b1;
              PSLVERR <= bus_err;
              PRDATA  <= bus_req_is_wr ? '0 : bus_rd_data;
            end
          end
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
          else if (timeout_hit) begin
            bus_req_stall_wr <= 1'b0;
            bus_req_stall_rd <= 1'b0;
            tmo_cnt          <= tmo_cnt + TMO_CW'(1);
            if (abandon) begin
              state <= S_IDLE;
            end else begin
              state   <= S_ERR;
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
              PRDATA  <= '0;
            end
          end
`endif
          else begin
            // Still outstanding: flag the stall for the request direction.
            state            <= S_WAIT;
            bus_req_stall_wr <= bus_req_is_wr;
            bus_req_stall_rd <= ~bus_req_is_wr;
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
            if (state == S_WAIT) begin
              tmo_cnt <= tmo_cnt + TMO_CW'(1);
            end
`endif
          end
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        S_ERR: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb4_reg_bridge
//
// Directed and randomized APB4 transfers against apb4_reg_bridge. The bench
// plays both the APB requester and the register map, records what the bridge
// does for each transfer and compares it with a transaction-level model.
// -----------------------------------------------------------------------------
module tb_apb4_reg_bridge;

  localparam int DW  = 32;
  localparam int AW  = 11;
  localparam int PAW = 32;
  localparam int TMO = 8;
  localparam int SW  = DW / 8;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           PSEL, PENABLE, PWRITE;
  logic [PAW-1:0] PADDR;
  logic [DW-1:0]  PWDATA;
  logic [SW-1:0]  PSTRB;
  logic [2:0]     PPROT;
  logic           PREADY;
  logic [DW-1:0]  PRDATA;
  logic           PSLVERR;
  logic           bus_req, bus_req_is_wr;
  logic [AW-1:0]  bus_addr;
  logic [DW-1:0]  bus_wr_data;
  logic [SW-1:0]  bus_wr_biten;
  logic           bus_req_stall_wr, bus_req_stall_rd;
  logic           bus_ready, bus_err;
  logic [DW-1:0]  bus_rd_data;
  logic [2:0]     fsm_state;

  apb4_reg_bridge #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .APB_ADDR_WIDTH(PAW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .PSEL            (PSEL),
    .PENABLE         (PENABLE),
    .PWRITE          (PWRITE),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
    .PSTRB           (PSTRB),
    .PPROT           (PPROT),
    .PREADY          (PREADY),
    .PRDATA          (PRDATA),
    .PSLVERR         (PSLVERR),
    .bus_req         (bus_req),
    .bus_req_is_wr   (bus_req_is_wr),
    .bus_addr        (bus_addr),
    .bus_wr_data     (bus_wr_data),
    .bus_wr_biten    (bus_wr_biten),
    .bus_req_stall_wr(bus_req_stall_wr),
    .bus_req_stall_rd(bus_req_stall_rd),
    .bus_ready       (bus_ready),
    .bus_err         (bus_err),
    .bus_rd_data     (bus_rd_data),
    .fsm_state       (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [PAW-1:0] addr;
    logic           wr;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  strb;
    int             n_wait;   // cycles from bus_req until the map answers
    logic           err;
    logic [DW-1:0]  rdata;
  } xfer_t;

  typedef struct {
    int            n_req;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] biten;
    int            n_stall_wr;
    int            n_stall_rd;
    int            pready_cyc; // access-cycle index of PREADY, -1 if none
    logic [DW-1:0] prdata;
    logic          pslverr;
    int            n_early_err;
  } xfer_res_t;

  function automatic xfer_res_t clear_res();
    xfer_res_t r;
    r.n_req       = 0;
    r.addr        = '0;
    r.wr          = 1'b0;
    r.wdata       = '0;
    r.biten       = '0;
    r.n_stall_wr  = 0;
    r.n_stall_rd  = 0;
    r.pready_cyc  = -1;
    r.prdata      = '0;
    r.pslverr     = 1'b0;
    r.n_early_err = 0;
    return r;
  endfunction

  // Transaction-level reference: what one complete APB transfer must look like.
  function automatic xfer_res_t model(input xfer_t t);
    xfer_res_t e;
    e = clear_res();
    if (t.addr >= (PAW'(1) << AW)) begin
      e.pready_cyc = 1;
      e.pslverr    = 1'b1;
      e.prdata     = '0;
    end else begin
      e.n_req      = 1;
      e.addr       = AW'(t.addr % (PAW'(1) << AW));
      e.wr         = t.wr;
      e.wdata      = t.wdata;
      e.biten      = t.wr ? t.strb : '0;
      e.n_stall_wr = t.wr ? t.n_wait : 0;
      e.n_stall_rd = t.wr ? 0 : t.n_wait;
      e.pready_cyc = t.n_wait + 2;
      e.prdata     = t.wr ? '0 : t.rdata;
      e.pslverr    = t.err;
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  // Runs one APB transfer and answers as the register map. Returns in the
  // cycle PREADY is seen with PSEL/PENABLE still high, so a following call
  // produces a back-to-back setup phase.
  task automatic run_xfer(input xfer_t t, output xfer_res_t r);
    int since;
    r = clear_res();
    @(posedge clk); #1;
    PSEL        = 1'b1;
    PENABLE     = 1'b0;
    PWRITE      = t.wr;
    PADDR       = t.addr;
    PWDATA      = t.wdata;
    PSTRB       = t.strb;
    PPROT       = 3'($urandom_range(0, 7));
    bus_ready   = 1'b0;
    bus_err     = 1'b0;
    since       = -1;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    for (int c = 1; c <= 64 && r.pready_cyc < 0; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (bus_req) begin
        r.n_req++;
        r.addr  = bus_addr;
        r.wr    = bus_req_is_wr;
        r.wdata = bus_wr_data;
        r.biten = bus_wr_biten;
        since   = 0;
      end else if (since >= 0) begin
        since++;
      end
      if (bus_req_stall_wr) r.n_stall_wr++;
      if (bus_req_stall_rd) r.n_stall_rd++;
      if (PREADY) begin
        r.pready_cyc = c;
        r.prdata     = PRDATA;
        r.pslverr    = PSLVERR;
      end else if (PSLVERR) begin
        r.n_early_err++;
      end
      if (since >= 0 && since == t.n_wait) begin
        bus_ready   = 1'b1;
        bus_err     = t.err;
        bus_rd_data = t.rdata;
      end else begin
        // Noise on err/data while not ready must not leak through.
        bus_ready   = 1'b0;
        bus_err     = 1'($urandom_range(0, 1));
        bus_rd_data = $urandom();
      end
    end
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      bus_ready = 1'b0;
    end
  endtask

  logic [DW-1:0] exp_hold = '0;  // PRDATA the bench expects to be held

  task automatic compare(input string tag, input xfer_t t, input xfer_res_t r);
    xfer_res_t e;
    e = model(t);
    check({tag, ".n_req"}, 64'(r.n_req), 64'(e.n_req));
    if (e.n_req == 1) begin
      check({tag, ".addr"},  64'(r.addr),  64'(e.addr));
      check({tag, ".is_wr"}, 64'(r.wr),    64'(e.wr));
      check({tag, ".wdata"}, 64'(r.wdata), 64'(e.wdata));
      check({tag, ".biten"}, 64'(r.biten), 64'(e.biten));
    end
    check({tag, ".stall_wr"},   64'(r.n_stall_wr),  64'(e.n_stall_wr));
    check({tag, ".stall_rd"},   64'(r.n_stall_rd),  64'(e.n_stall_rd));
    check({tag, ".pready_cyc"}, 64'(r.pready_cyc),  64'(e.pready_cyc));
    check({tag, ".prdata"},     64'(r.prdata),      64'(e.prdata));
    check({tag, ".pslverr"},    64'(r.pslverr),     64'(e.pslverr));
    check({tag, ".early_err"},  64'(r.n_early_err), 64'(0));
    exp_hold = e.prdata;
  endtask

  function automatic xfer_t mk(input logic [PAW-1:0] addr, input logic wr,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                               input int n_wait, input logic err, input logic [DW-1:0] rdata);
    xfer_t t;
    t.addr = addr; t.wr = wr; t.wdata = wdata; t.strb = strb;
    t.n_wait = n_wait; t.err = err; t.rdata = rdata;
    return t;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    xfer_t     t;
    xfer_res_t r;
    int        n_rdy, n_err, n_req, n_bad_hold;

    rst = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
    PWDATA = '0; PSTRB = '0; PPROT = '0;
    bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.pready",  64'(PREADY),  64'(0));
    check("rst.pslverr", 64'(PSLVERR), 64'(0));
    check("rst.prdata",  64'(PRDATA),  64'(0));
    check("rst.bus_req", 64'(bus_req), 64'(0));
    check("rst.state",   64'(fsm_state), 64'(0));
    rst = 1'b1;

    // Write, zero wait states
    t = mk(32'h0000_0010, 1'b1, 32'hA5A5_1234, 4'hF, 0, 1'b0, 32'h0);
    run_xfer(t, r);
    compare("wr0", t, r);

    // Read, three wait states
    t = mk(32'h0000_0024, 1'b0, 32'h1111_2222, 4'h0, 3, 1'b0, 32'hCAFE_F00D);
    run_xfer(t, r);
    compare("rd3", t, r);

    // Out of range address
    t = mk(32'h0000_0800, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0);
    run_xfer(t, r);
    compare("oor", t, r);

    // Register error with partial strobes
    t = mk(32'h0000_03FC, 1'b1, 32'hDEAD_BEEF, 4'h3, 1, 1'b1, 32'h0);
    run_xfer(t, r);
    compare("err_strb", t, r);

    // Read to load PRDATA with something nonzero before the reset test
    t = mk(32'h0000_0100, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h7654_3210);
    run_xfer(t, r);
    compare("rd_pre_rst", t, r);

    // Reset while waiting for the register map
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0000_0020;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    check("mrst.bus_req", 64'(bus_req), 64'(1));
    @(posedge clk); #1;
    check("mrst.stall_rd", 64'(bus_req_stall_rd), 64'(1));
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("mrst.stall_rd0", 64'(bus_req_stall_rd), 64'(0));
    check("mrst.prdata0",   64'(PRDATA),   64'(0));
    check("mrst.bus_addr0", 64'(bus_addr), 64'(0));
    check("mrst.state0",    64'(fsm_state), 64'(0));
    exp_hold = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      bus_ready = (i == 0);
      @(posedge clk); #1;
      n_rdy += int'(PREADY);
    end
    bus_ready = 1'b0;
    check("mrst.no_pready", 64'(n_rdy), 64'(0));
    go_idle(1);
    t = mk(32'h0000_0044, 1'b1, 32'h0BAD_F00D, 4'hC, 2, 1'b0, 32'h0);
    run_xfer(t, r);
    compare("after_rst", t, r);

    // PSEL dropped while the bus side is outstanding
    go_idle(1);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0000_0048;
    PWDATA = 32'h1234_5678; PSTRB = 4'hF;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("drop.stall_wr", 64'(bus_req_stall_wr), 64'(1));
    @(posedge clk); #1;
    bus_ready = 1'b1;
    n_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus_ready = 1'b0;
      n_rdy += int'(PREADY);
    end
    check("drop.no_pready", 64'(n_rdy), 64'(0));
    check("drop.state",     64'(fsm_state), 64'(0));
    check("drop.stall_clr", 64'(bus_req_stall_wr), 64'(0));

    // Randomized transfers, mostly back-to-back
    for (int n = 0; n < 40; n++) begin
      t.wr    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        t.addr = {21'($urandom_range(1, 32'h1F_FFFF)), 11'($urandom())};
      else
        t.addr = {21'd0, 11'($urandom())};
      t.wdata  = $urandom();
      t.strb   = 4'($urandom_range(0, 15));
      t.n_wait = int'($urandom_range(0, 5));
      t.err    = 1'($urandom_range(0, 1));
      t.rdata  = $urandom();
      run_xfer(t, r);
      compare($sformatf("rnd%0d", n), t, r);
      if ($urandom_range(0, 3) == 0) go_idle(int'($urandom_range(1, 2)));
    end

    // bus_ready / bus_err while idle are ignored; PRDATA holds
    go_idle(1);
    n_rdy = 0; n_err = 0; n_req = 0; n_bad_hold = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_rdy += int'(PREADY);
      n_err += int'(PSLVERR);
      n_req += int'(bus_req);
      if (PRDATA !== exp_hold) n_bad_hold++;
      bus_ready   = 1'b1;
      bus_err     = 1'b1;
      bus_rd_data = $urandom();
    end
    bus_ready = 1'b0;
    bus_err   = 1'b0;
    check("idle.pready",  64'(n_rdy),      64'(0));
    check("idle.pslverr", 64'(n_err),      64'(0));
    check("idle.bus_req", 64'(n_req),      64'(0));
    check("idle.hold",    64'(n_bad_hold), 64'(0));
    check("idle.state",   64'(fsm_state),  64'(0));

`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
    // Register map never answers: error after TMO wait cycles
    t = mk(32'h0000_0030, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h5555_AAAA);
    run_xfer(t, r);
    check("tmo.n_req",      64'(r.n_req),      64'(1));
    check("tmo.stall_rd",   64'(r.n_stall_rd), 64'(TMO));
    check("tmo.pready_cyc", 64'(r.pready_cyc), 64'(TMO + 2));
    check("tmo.pslverr",    64'(r.pslverr),    64'(1));
    check("tmo.prdata",     64'(r.prdata),     64'(0));
    go_idle(1);
    n_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      bus_ready   = 1'b1;
      bus_rd_data = 32'h5555_AAAA;
      @(posedge clk); #1;
      n_rdy += int'(PREADY);
    end
    bus_ready = 1'b0;
    check("tmo.late_ready", 64'(n_rdy),  64'(0));
    check("tmo.prdata_hold", 64'(PRDATA), 64'(0));
`endif

    go_idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb4_reg_bridge.md
Name: apb4_reg_bridge

Overview:
- APB4 completer front end that converts APB4 transfers into single-request register-bus transactions on the Bus2Reg_intf BUS side. The register map consumes these on REG_MAP.
- Sits between the SoC APB4 fabric and the CSR/register-map block.
- Adds registered request issue, wait-state insertion until the register map responds, and an address-range error check.

Parameters:
DATA_WIDTH, 32, APB and register-bus data width; must be a multiple of 8
ADDR_WIDTH, 11, register-bus address width
APB_ADDR_WIDTH, 32, PADDR width; must be >= ADDR_WIDTH
TIMEOUT_CYCLES, 256, maximum wait for bus_ready; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PADDR  in  APB_ADDR_WIDTH  APB address
PWDATA  in  DATA_WIDTH  APB write data
PSTRB  in  DATA_WIDTH/8  APB write strobes
PPROT  in  3  APB protection; ignored
PREADY  out  1  APB ready
PRDATA  out  DATA_WIDTH  APB read data
PSLVERR  out  1  APB error
bus_req  out  1  register request, one-cycle pulse
bus_req_is_wr  out  1  1 = write request
bus_addr  out  ADDR_WIDTH  register address
bus_wr_data  out  DATA_WIDTH  write data
bus_wr_biten  out  DATA_WIDTH/8  byte enables
bus_req_stall_wr  out  1  write outstanding, waiting for bus_ready
bus_req_stall_rd  out  1  read outstanding, waiting for bus_ready
bus_ready  in  1  register-map completion
bus_err  in  1  register-map error, sampled with bus_ready
bus_rd_data  in  DATA_WIDTH  read data, sampled with bus_ready

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs are 0 and the FSM goes to IDLE.
  - A transfer in flight is discarded; no PREADY is issued for it after reset release.
- Signals captured in the setup phase (PSEL=1, PENABLE=0):
  - PADDR[ADDR_WIDTH-1:0] is registered to bus_addr.
  - PWRITE is registered to bus_req_is_wr.
  - PWDATA is registered to bus_wr_data.
  - bus_wr_biten is registered as PSTRB for writes and 0 for reads.
- FSM states:
  - IDLE: on setup phase with PADDR[APB_ADDR_WIDTH-1:ADDR_WIDTH] == 0, go to REQ. On setup phase with a nonzero upper address, go to ERR.
  - REQ (first access cycle): bus_req=1 for exactly this one cycle. If bus_ready=1 in this cycle, latch the response and go to RESP. Otherwise go to WAIT.
  - WAIT: bus_req=0; bus_req_stall_wr or bus_req_stall_rd is 1 according to bus_req_is_wr. Stay in WAIT until bus_ready=1, then latch the response and go to RESP.
  - RESP: PREADY=1 for one cycle. PRDATA carries the latched bus_rd_data for reads and 0 for writes. PSLVERR carries the latched bus_err. Go to IDLE.
  - ERR: issue no bus_req; PREADY=1 and PSLVERR=1 for one cycle, PRDATA=0. Go to IDLE.
- Latency:
  - Best case is setup + 2 access cycles (bus_ready in the REQ cycle).
  - In general, PREADY rises the cycle after bus_ready is sampled.
- Outside RESP and ERR: PREADY=0 and PSLVERR=0. PRDATA holds its last value.
- bus_ready or bus_err arriving in IDLE is ignored.
- PSEL dropping before completion (protocol violation): the bridge finishes the bus-side handshake and returns to IDLE, but suppresses PREADY.
- Back-to-back transfers: a new setup phase in the cycle after RESP is accepted normally.
- Only one request is outstanding at a time; bus_req is never reasserted while in WAIT.

Optional Feature:
- Macro: APB4_REG_BRIDGE_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) starts at REQ and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES without bus_ready, the FSM goes to ERR: PSLVERR=1, PRDATA=0.
  - The counter clears in IDLE.
  - A bus_ready that arrives after the timeout is ignored.
- When not defined: no counter is built, and WAIT lasts indefinitely.

Test Plan:
- Write, zero wait: PADDR=0x010, PWDATA=0xA5A5_1234, PSTRB=0xF, bus_ready in the REQ cycle -> one bus_req pulse with addr 0x010, biten 0xF; PREADY on the 2nd access cycle; PSLVERR=0.
- Read, 3 wait states: bus_ready 3 cycles after bus_req, rd_data=0xCAFE_F00D -> bus_req_stall_rd=1 for 3 cycles; PREADY one cycle later with PRDATA=0xCAFE_F00D.
- Out-of-range: PADDR=0x0000_0800 with ADDR_WIDTH=11 -> no bus_req; PREADY=1, PSLVERR=1, PRDATA=0.
- Register error plus partial strobe: write with PSTRB=0x3 and bus_err=1 with bus_ready -> bus_wr_biten=0x3; PSLVERR=1 in the RESP cycle.
- Reset mid-WAIT: rst=0 while waiting -> all outputs 0 immediately; after release, no PREADY; the next transfer completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8): bus_ready never asserted -> PREADY=1, PSLVERR=1 after 8 wait cycles; a bus_ready arriving later has no effect.
